// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB requester and its companion slave.
// The response struct is sized for the shared default data width.
package apb_master_pkg;

  localparam int unsigned APB_ADDR_W      = 32;
  localparam int unsigned APB_DATA_W      = 32;
  localparam int unsigned APB_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  // A zero timeout still needs a 1-bit counter so every width stays legal.
  function automatic int unsigned timer_width(int unsigned cyc);
    return (cyc == 0) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// APB bus bundle between a requester (master modport) and a responder (slave modport).
interface apb_master_if
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
);

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_master_wait_timer.sv
// Counts ACCESS wait cycles; expired marks the last cycle allowed before abort.
// The count saturates instead of wrapping, so a stuck slave can never re-arm it.
module apb_master_wait_timer
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned     CNT_W  = timer_width(TIMEOUT_CYC);
  localparam bit              ACTIVE = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] LIMIT = ACTIVE ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; async reset on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = ACTIVE && (count_q == LIMIT);

endmodule

// File: rtl/apb_master.sv
// APB requester: one valid/ready command becomes one SETUP/ACCESS transfer, and the
// result (read data, slave error, timeout) is held on the response channel until taken.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  apb_master_if.master      apb
);

  apb_state_e        state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  apb_rsp_t          rsp_q, rsp_d;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  apb_master_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_d       = rsp_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          timer_clear = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready is checked before the timer so a completion on the last allowed cycle wins.
        if (apb.pready) begin
          rsp_d.rdata   = pwrite_q ? '0 : APB_DATA_W'(apb.prdata);
          rsp_d.err     = apb.pslverr;
          rsp_d.timeout = 1'b0;
          state_d       = RESP;
        end else if (timer_expired) begin
          rsp_d.rdata   = '0;
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
          state_d       = RESP;
        end else begin
          timer_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rsp_q    <= rsp_d;
    end
  end

  // Handshake and bus strobes decode straight from the state register.
  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = DATA_W'(rsp_q.rdata);
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

  assign apb.psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb.penable = (state_q == ACCESS);
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a behavioural APB memory slave plus a transaction-level model
// predicting latency, response fields and memory contents for directed and random traffic.
module tb_apb_master;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 16;
  localparam int MAX_LAT     = 40;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  int total = 0;
  int bad   = 0;
  time last_accept_t = 0;

  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb         (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // One command end to end; entered and left on a negedge with the DUT idle.
  task automatic run_txn(input string name, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int waits, input logic serr,
                         input int hold);
    bit                tmo;
    int                exp_lat;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
    int                lat;
    int                acc;
    bit                got;
    bit                unstable;
    bit                hold_bad;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err, r_tmo;

    tmo       = (TIMEOUT_CYC != 0) && (waits >= TIMEOUT_CYC);
    exp_lat   = tmo ? TIMEOUT_CYC + 2 : waits + 3;
    exp_rdata = (wr || tmo) ? '0 : mem_rd(addr);
    exp_err   = tmo || serr;

    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s idle_ready: got cmd_ready=%b want 1", name, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    last_accept_t = $time;

    @(negedge clk);
    lat = 1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    total++;
    if (!(bus.psel === 1'b1 && bus.penable === 1'b0 && bus.paddr === addr &&
          bus.pwrite === wr && (!wr || bus.pwdata === wdata))) begin
      bad++;
      $display("FAIL %s setup: got psel=%b penable=%b paddr=%h pwrite=%b want 1 0 %h %b",
               name, bus.psel, bus.penable, bus.paddr, bus.pwrite, addr, wr);
    end
    // Junk on pready/pslverr during SETUP must be ignored.
    bus.pready  = 1'($urandom);
    bus.pslverr = 1'($urandom);
    bus.prdata  = $urandom;

    acc = 0;
    got = 0;
    unstable = 0;
    while (lat < MAX_LAT) begin
      @(negedge clk);
      lat++;
      if (rsp_valid === 1'b1) begin
        got = 1;
        break;
      end
      if (!(bus.psel === 1'b1 && bus.penable === 1'b1 && bus.paddr === addr &&
            bus.pwrite === wr && (!wr || bus.pwdata === wdata))) unstable = 1;
      bus.pready  = (acc >= waits);
      bus.pslverr = bus.pready ? serr : 1'($urandom);
      bus.prdata  = (bus.pready && !wr) ? mem_rd(addr) : $urandom;
      acc++;
    end
    bus.pready  = 1'($urandom);
    bus.pslverr = 1'($urandom);
    bus.prdata  = $urandom;

    total++;
    if (unstable) begin
      bad++;
      $display("FAIL %s access_stable: got bus changed during ACCESS want stable addr=%h", name, addr);
    end

    total++;
    if (!got || lat != exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d (seen=%0d) want %0d", name, lat, got, exp_lat);
    end

    if (!got) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      return;
    end

    if (wr && !tmo && !serr) mem[addr] = wdata;

    total++;
    if (rsp_rdata !== exp_rdata || rsp_err !== exp_err || rsp_timeout !== tmo ||
        bus.psel !== 1'b0 || bus.penable !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s response: got rdata=%h err=%b tmo=%b psel=%b pen=%b rdy=%b want %h %b %b 0 0 0",
               name, rsp_rdata, rsp_err, rsp_timeout, bus.psel, bus.penable, cmd_ready,
               exp_rdata, exp_err, tmo);
    end

    r_rdata = rsp_rdata;
    r_err   = rsp_err;
    r_tmo   = rsp_timeout;
    hold_bad = 0;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== r_rdata || rsp_err !== r_err ||
          rsp_timeout !== r_tmo || cmd_ready !== 1'b0 || bus.psel !== 1'b0) hold_bad = 1;
    end
    if (hold > 0) begin
      total++;
      if (hold_bad) begin
        bad++;
        $display("FAIL %s rsp_hold: got response changed or cmd_ready/psel set want stable for %0d cycles",
                 name, hold);
      end
    end

    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || bus.psel !== 1'b0) begin
      bad++;
      $display("FAIL %s release: got rsp_valid=%b cmd_ready=%b psel=%b want 0 1 0",
               name, rsp_valid, cmd_ready, bus.psel);
    end
  endtask

  task automatic test_reset();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.pwrite !== 1'b0 ||
        bus.paddr !== '0 || bus.pwdata !== '0 || rsp_valid !== 1'b0 ||
        rsp_rdata !== '0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b rd=%h err=%b tmo=%b rdy=%b want all 0, rdy=1",
               bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, rsp_valid,
               rsp_rdata, rsp_err, rsp_timeout, cmd_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_basic();
    run_txn("write_basic", 1'b1, 32'h10, 32'hA5A5_0001, 0, 1'b0, 0);
  endtask

  task automatic test_read_waits();
    run_txn("read_2wait", 1'b0, 32'h10, 32'h0, 2, 1'b0, 0);
  endtask

  task automatic test_read_slverr();
    run_txn("read_slverr", 1'b0, 32'h10, 32'h0, 1, 1'b1, 0);
    run_txn("write_slverr", 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b1, 0);
    run_txn("read_after_err", 1'b0, 32'h10, 32'h0, 0, 1'b0, 0);
  endtask

  task automatic test_timeout();
    run_txn("read_timeout", 1'b0, 32'h10, 32'h0, 100, 1'b0, 0);
    run_txn("write_timeout", 1'b1, 32'h14, 32'h1234_5678, 100, 1'b0, 1);
    run_txn("pready_on_last", 1'b0, 32'h10, 32'h0, TIMEOUT_CYC - 1, 1'b0, 0);
    run_txn("pready_one_late", 1'b0, 32'h10, 32'h0, TIMEOUT_CYC, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_txn("backpressure", 1'b1, 32'h20, 32'h0BAD_F00D, 0, 1'b0, 5);
    run_txn("after_release", 1'b0, 32'h20, 32'h0, 0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    time t0;
    run_txn("b2b_0", 1'b1, 32'h30, 32'h1111_2222, 0, 1'b0, 0);
    t0 = last_accept_t;
    run_txn("b2b_1", 1'b0, 32'h30, 32'h0, 0, 1'b0, 0);
    total++;
    if (last_accept_t - t0 != 40) begin
      bad++;
      $display("FAIL b2b_spacing: got %0t want 40", last_accept_t - t0);
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h44;
    cmd_wdata = 32'hCAFE_0044;
    bus.pready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.psel !== 1'b1 || bus.penable !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_access: got psel=%b pen=%b want 1 1", bus.psel, bus.penable);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_async: got psel=%b pen=%b want 0 0", bus.psel, bus.penable);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || bus.psel !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_after: got rdy=%b rv=%b psel=%b want 1 0 0",
               cmd_ready, rsp_valid, bus.psel);
    end
    run_txn("read_after_reset", 1'b0, 32'h44, 32'h0, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    int w;
    for (int i = 0; i < 30; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 7) * 4);
      w = ($urandom_range(0, 9) == 0) ? TIMEOUT_CYC + 1 : int'($urandom_range(0, 4));
      run_txn("random", 1'($urandom), a, $urandom, w, ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_waits();
    test_read_slverr();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
